// File: rtl/dcache_pkg.sv
// Shared types and address-field constants for the direct-mapped data cache controller.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWAP_OUT,
        SWAP_IN,
        SWAP_IN_OK
    } state_e;

    localparam int unsigned LINE_ADDR_LEN_DEF = 3;
    localparam int unsigned SET_ADDR_LEN_DEF  = 3;
    localparam int unsigned BYTE_ADDR_LEN     = 2;
    localparam int unsigned WORD_BITS         = 32;
    localparam int unsigned TAG_ADDR_LEN_DEF  = WORD_BITS - BYTE_ADDR_LEN - LINE_ADDR_LEN_DEF - SET_ADDR_LEN_DEF;

    function automatic int unsigned tag_len(input int unsigned line_len, input int unsigned set_len);
        return WORD_BITS - BYTE_ADDR_LEN - line_len - set_len;
    endfunction

endpackage

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache for the MEM stage; swaps whole lines
// with main memory over a request/grant handshake and stalls the pipeline via miss.
import dcache_pkg::*;

module dcache_ctrl #(
    parameter int unsigned LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int unsigned SET_ADDR_LEN  = SET_ADDR_LEN_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 rd_req,
    input  logic                                 wr_req,
    input  logic [31:0]                          addr,
    input  logic [31:0]                          wr_data,
    output logic [31:0]                          rd_data,
    output logic                                 miss,
    output logic                                 mem_rd_req,
    output logic                                 mem_wr_req,
    output logic [31:0]                          mem_addr,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]     mem_wr_line,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]     mem_rd_line,
    input  logic                                 mem_gnt
);

    localparam int unsigned WORDS     = 2 ** LINE_ADDR_LEN;
    localparam int unsigned SETS      = 2 ** SET_ADDR_LEN;
    localparam int unsigned TAG_LEN   = tag_len(LINE_ADDR_LEN, SET_ADDR_LEN);
    localparam int unsigned LINE_BITS = WORD_BITS * WORDS;
    localparam int unsigned SET_LSB   = BYTE_ADDR_LEN + LINE_ADDR_LEN;
    localparam int unsigned TAG_LSB   = SET_LSB + SET_ADDR_LEN;

    state_e                   state_q, state_d;
    logic [SETS-1:0]          valid_q, dirty_q;
    logic [TAG_LEN-1:0]       tag_q  [SETS];
    logic [LINE_BITS-1:0]     data_q [SETS];
    logic [31:0]              miss_addr_q, miss_addr_d;
    logic [LINE_BITS-1:0]     fill_q, fill_d;
    logic                     mem_rd_req_q, mem_rd_req_d;
    logic                     mem_wr_req_q, mem_wr_req_d;
    logic [31:0]              mem_addr_q, mem_addr_d;

    logic [LINE_ADDR_LEN-1:0] word_idx;
    logic [SET_ADDR_LEN-1:0]  set_idx, miss_set, nxt_set;
    logic [TAG_LEN-1:0]       req_tag, miss_tag;
    logic                     req, hit, store_hit;
    logic                     unused_addr_bits;

    assign word_idx = addr[SET_LSB-1:BYTE_ADDR_LEN];
    assign set_idx  = addr[TAG_LSB-1:SET_LSB];
    assign req_tag  = addr[31:TAG_LSB];
    assign miss_set = miss_addr_q[TAG_LSB-1:SET_LSB];
    assign miss_tag = miss_addr_q[31:TAG_LSB];
    assign nxt_set  = miss_addr_d[TAG_LSB-1:SET_LSB];

    assign unused_addr_bits = ^{addr[BYTE_ADDR_LEN-1:0], miss_addr_q[SET_LSB-1:0]};

    assign req       = rd_req | wr_req;
    assign hit       = valid_q[set_idx] && (tag_q[set_idx] == req_tag);
    assign store_hit = (state_q == IDLE) && wr_req && hit;

    assign rd_data     = data_q[set_idx][{word_idx, 5'd0} +: 32];
    assign miss        = (state_q != IDLE) || (req && !hit);
    assign mem_rd_req  = mem_rd_req_q;
    assign mem_wr_req  = mem_wr_req_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_line = data_q[miss_set];

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        fill_d      = fill_q;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    miss_addr_d = addr;
                    state_d     = (valid_q[set_idx] && dirty_q[set_idx]) ? SWAP_OUT : SWAP_IN;
                end
            end
            SWAP_OUT: begin
                if (mem_gnt) state_d = SWAP_IN;
            end
            SWAP_IN: begin
                if (mem_gnt) begin
                    fill_d  = mem_rd_line;
                    state_d = SWAP_IN_OK;
                end
            end
            SWAP_IN_OK: state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        // Request outputs are registered from the next state so they appear the cycle after entry.
        mem_wr_req_d = (state_d == SWAP_OUT);
        mem_rd_req_d = (state_d == SWAP_IN);
        mem_addr_d   = '0;
        if (state_d == SWAP_OUT)
            mem_addr_d = {tag_q[nxt_set], nxt_set, {SET_LSB{1'b0}}};
        else if (state_d == SWAP_IN)
            mem_addr_d = {miss_addr_d[31:SET_LSB], {SET_LSB{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            miss_addr_q  <= '0;
            fill_q       <= '0;
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            fill_q       <= fill_d;
            mem_rd_req_q <= mem_rd_req_d;
            mem_wr_req_q <= mem_wr_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                tag_q[s]  <= '0;
                data_q[s] <= '0;
            end
        end else if (store_hit) begin
            data_q[set_idx][{word_idx, 5'd0} +: 32] <= wr_data;
            dirty_q[set_idx]                        <= 1'b1;
        end else if (state_q == SWAP_IN_OK) begin
            data_q[miss_set]  <= fill_q;
            tag_q[miss_set]   <= miss_tag;
            valid_q[miss_set] <= 1'b1;
            dirty_q[miss_set] <= 1'b0;
        end
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller for the memory stage of the RISC-V pipeline. It serves word loads and stores from the MEM stage and drives `miss`, which is wired to the hazard unit's `DCacheMiss` input so the pipeline stalls while a line is swapped. It talks line-at-a-time to main memory over a request/grant handshake.

## Interface
- `LINE_ADDR_LEN`, 3: log2 words per line; 8 words/line.
- `SET_ADDR_LEN`, 3: log2 sets; 8 sets.
- Tag width is derived as `32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN`; 24 with defaults.

- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rd_req` in 1: load request from MEM stage.
- `wr_req` in 1: store request from MEM stage.
- `addr` in 32: byte address; bits [1:0] ignored.
- `wr_data` in 32: store word.
- `rd_data` out 32: load word, combinational on hit.
- `miss` out 1: to hazard unit `DCacheMiss`.
- `mem_rd_req` out 1: line fill request.
- `mem_wr_req` out 1: line write-back request.
- `mem_addr` out 32: line-aligned byte address; word/byte bits are 0.
- `mem_wr_line` out 32·2^LINE_ADDR_LEN: victim line; word i is at bits [32i+31:32i].
- `mem_rd_line` in 32·2^LINE_ADDR_LEN: fill line, valid in the `mem_gnt` cycle.
- `mem_gnt` in 1: one-cycle completion pulse for the current memory request.

## Operation
- Address split: [1:0] byte, [LINE+1:2] word, next SET_ADDR_LEN bits set, rest tag. Defaults: [4:2] word, [7:5] set, [31:8] tag.
- Per set: valid, dirty, tag, line data.
- Hit: `req = rd_req|wr_req`, `valid[set] && tag[set]==addr tag`.
- `wr_req` has priority when both requests are asserted; the access is then a store.
- `miss = (state!=IDLE) || (req && !hit)`.
- `rd_data` is the addressed word of the indexed line, independent of hit; it is meaningful only when `miss=0`.
- Write hit in IDLE: the word is written and `dirty` set on the rising edge.
- FSM states: IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK.
  - IDLE, req && !hit: latch `addr` into `miss_addr`. Go to SWAP_OUT if the victim is valid and dirty, else SWAP_IN.
  - SWAP_OUT: `mem_wr_req=1`, `mem_addr={victim tag,set,0}`, `mem_wr_line`=victim line. On `mem_gnt`, go to SWAP_IN.
  - SWAP_IN: `mem_rd_req=1`, `mem_addr` = line base of `miss_addr`. On `mem_gnt`, capture `mem_rd_line` and go to SWAP_IN_OK.
  - SWAP_IN_OK: write the captured line, tag, valid=1, dirty=0, then go to IDLE.
- The pending access replays as a normal hit in IDLE, because the pipeline holds its request while stalled.
- Request dropped mid-swap (pipeline flush): the swap still completes. `miss` stays 1 until IDLE.
- `mem_gnt` outside SWAP_OUT/SWAP_IN is ignored.
- `mem_rd_req` and `mem_wr_req` are never both 1.

## Timing
- Reset (async): state=IDLE, all valid/dirty/tag/data cleared to 0. `mem_rd_req=mem_wr_req=0`, `mem_addr=0`, `rd_data=0`, `miss=0` (no request).
- Hit: zero extra cycles; load data in the same cycle, store commits at the edge.
- Memory requests are registered outputs, asserted the cycle after entering the state. They are held through the `mem_gnt` cycle and low the following cycle.
- Clean miss: `miss` rises combinationally in the request cycle, then SWAP_IN for 1+G cycles (G = memory gnt delay), then one SWAP_IN_OK cycle. `miss` falls in the following IDLE cycle, which is the hit/replay.
- Dirty miss adds a SWAP_OUT phase of the same form.
- Reset mid-swap aborts immediately; the partially fetched line is discarded.

## Structure
- Package `dcache_pkg`: state enum (IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK), default LINE/SET lengths, derived TAG width, and address-field slicing constants.
- Single module; the storage arrays are inline registers, with no sub-module required.

## Test plan
- After reset, rd 0x10: `miss=1` and next cycle `mem_rd_req=1`, `mem_addr=0x00`. With gnt after 3 cycles and line word4=0xDEADBEEF, `miss` falls and `rd_data=0xDEADBEEF`.
- Write hit: wr 0x14 data 0x12345678, then rd 0x14 gives `miss=0`, `rd_data=0x12345678`, no memory request.
- Dirty eviction: after the write above, rd 0x114 gives `mem_wr_req`, `mem_addr=0x000`, `mem_wr_line` word5=0x12345678. This is followed by `mem_rd_req`, `mem_addr=0x100`; then a rd of 0x14 misses again.
- Simultaneous `rd_req`/`wr_req` to resident 0x18 with 0xA5A5A5A5: the store is performed and a later rd returns 0xA5A5A5A5.
- `rst_n` low during SWAP_IN: `mem_rd_req` and `miss` drop asynchronously; after release, rd 0x10 misses.
- `mem_gnt` pulsed while IDLE: no state change, no array update.
